// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets several byte-stream requesters share one UART
// transmitter. A port owns the transmitter for a whole message (until its tlast
// beat) or until it stays silent for TIMEOUT consecutive cycles.

module uart_tx_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,

    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,

    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy,
    output logic                            timeout_err
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Release fires when the counter already holds TIMEOUT-1 and one more
    // silent cycle arrives, i.e. on the TIMEOUT-th consecutive silent cycle.
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT - 1);
    // Saturation ceiling; the release normally triggers well before this.
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(TIMEOUT);
    // Out of reset the "previous owner" is the top port so port 0 wins first.
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] ONE_HOT_0 = NUM_PORTS'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_reg,       state_next;
    logic [NUM_PORTS-1:0]   grant_reg,       grant_next;
    logic [IDX_W-1:0]       owner_reg,       owner_next;
    logic [IDX_W-1:0]       last_owner_reg,  last_owner_next;
    logic [CNT_W-1:0]       cnt_reg,         cnt_next;
    logic                   timeout_err_reg, timeout_err_next;

    // ------------------------------------------------------------------
    // Per-port views of the packed input bus
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  port_data [NUM_PORTS];
    logic                   pass_active;

    // Outputs toward the requesters are forced low while reset is high so
    // nothing can be accepted on the aborting edge.
    assign pass_active = (state_reg == ST_PASS) && !rst;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_data[gi]     = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_axis_tready[gi] = pass_active & grant_reg[gi] & m_axis_tready;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Owner mux
    // ------------------------------------------------------------------
    logic                   owner_valid;
    logic                   owner_last;
    logic [DATA_WIDTH-1:0]  owner_data;
    logic                   beat;

    assign owner_valid = s_axis_tvalid[owner_reg];
    assign owner_last  = s_axis_tlast[owner_reg];
    assign owner_data  = port_data[owner_reg];

    // A byte moves only in PASS with both handshake sides high.
    assign beat = (state_reg == ST_PASS) && owner_valid && m_axis_tready;

    // ------------------------------------------------------------------
    // Round-robin pick: first requesting port strictly after last_owner
    // ------------------------------------------------------------------
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       cand;
    logic [NUM_PORTS-1:0]   pick_onehot;

    // Scan offsets 1..NUM_PORTS so last_owner itself is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((int'(last_owner_reg) + k) % NUM_PORTS);
            if (!pick_found && s_axis_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_onehot = ONE_HOT_0 << pick_idx;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Arbitration in IDLE, message forwarding / timeout release in PASS.
    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        owner_next       = owner_reg;
        last_owner_next  = last_owner_reg;
        cnt_next         = cnt_reg;
        timeout_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Grant registers now; bytes start moving the cycle after.
                if (pick_found) begin
                    state_next = ST_PASS;
                    grant_next = pick_onehot;
                    owner_next = pick_idx;
                    cnt_next   = '0;
                end
            end

            ST_PASS: begin
                if (beat && owner_last) begin
                    // End of message: always pass through one IDLE cycle.
                    state_next      = ST_IDLE;
                    grant_next      = '0;
                    last_owner_next = owner_reg;
                    cnt_next        = '0;
                end else if (beat) begin
                    cnt_next = '0;
                end else if (!owner_valid) begin
                    // Owner silent this cycle. Backpressured cycles (valid
                    // high, ready low) fall through and never count.
                    if (cnt_reg == CNT_LIMIT) begin
                        state_next       = ST_IDLE;
                        grant_next       = '0;
                        last_owner_next  = owner_reg;
                        cnt_next         = '0;
                        timeout_err_next = 1'b1;
                    end else if (cnt_reg != CNT_SAT) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers with synchronous reset
    // ------------------------------------------------------------------
    // Reset aborts any message in flight on the edge where rst is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= '0;
            owner_reg       <= '0;
            last_owner_reg  <= LAST_RESET;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            owner_reg       <= owner_next;
            last_owner_reg  <= last_owner_next;
            cnt_reg         <= cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_axis_tvalid = pass_active & owner_valid;
    assign m_axis_tlast  = pass_active & owner_last;
    assign m_axis_tdata  = pass_active ? owner_data : '0;
    assign grant         = grant_reg;
    assign busy          = (state_reg == ST_PASS);
    assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed table of per-cycle vectors plus hand-written sequences for
// round-robin rotation, long backpressure and the idle timeout.
// Inputs change 1 ns after posedge; outputs are sampled 6 ns after posedge.

module tb_uart_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              clk;
    logic              rst;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [NP-1:0]     grant;
    logic              busy;
    logic              timeout_err;

    uart_tx_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant         (grant),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next cycle's input-drive point.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #5;
    endtask

    typedef struct {
        logic          rst;
        logic [NP-1:0] valid;
        logic [NP-1:0] last;
        logic [31:0]   data;
        logic          mready;
        logic [NP-1:0] e_grant;
        logic          e_mvalid;
        logic [7:0]    e_mdata;
        logic          e_mlast;
        logic [NP-1:0] e_tready;
        logic          e_busy;
        logic          e_terr;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [31:0] d, logic mr,
                                logic [3:0] eg, logic emv, logic [7:0] emd, logic eml,
                                logic [3:0] etr, logic eb, logic et);
        vec_t x;
        x.rst = r; x.valid = v; x.last = l; x.data = d; x.mready = mr;
        x.e_grant = eg; x.e_mvalid = emv; x.e_mdata = emd; x.e_mlast = eml;
        x.e_tready = etr; x.e_busy = eb; x.e_terr = et;
        return x;
    endfunction

    int bad_cnt;
    int terr_cnt;

    initial begin
        // ---------------- vector table ----------------
        //            rst valid  last   data          mr  grant  mv mdata ml  trdy   bsy ter
        // reset held with every port requesting: nothing may be accepted
        vecs[0]  = mk(1, 4'hF, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h00, 0, 4'h0, 0, 0);
        // ports 0 and 2 request together; port 0 wins, 3-byte message
        vecs[1]  = mk(0, 4'h5, 4'h0, 32'h00A0_0041, 1, 4'h0, 0, 8'h00, 0, 4'h0, 0, 0);
        vecs[2]  = mk(0, 4'h5, 4'h0, 32'h00A0_0041, 1, 4'h1, 1, 8'h41, 0, 4'h1, 1, 0);
        vecs[3]  = mk(0, 4'h5, 4'h0, 32'h00A0_0042, 1, 4'h1, 1, 8'h42, 0, 4'h1, 1, 0);
        vecs[4]  = mk(0, 4'h5, 4'h1, 32'h00A0_0043, 1, 4'h1, 1, 8'h43, 1, 4'h1, 1, 0);
        // one IDLE cycle, then port 2
        vecs[5]  = mk(0, 4'h4, 4'h4, 32'h00A0_0000, 1, 4'h0, 0, 8'h00, 0, 4'h0, 0, 0);
        vecs[6]  = mk(0, 4'h4, 4'h4, 32'h00A0_0000, 1, 4'h4, 1, 8'hA0, 1, 4'h4, 1, 0);
        vecs[7]  = mk(0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h00, 0, 4'h0, 0, 0);
        // port 1 mid-message, then a one-cycle reset
        vecs[8]  = mk(0, 4'h2, 4'h0, 32'h0000_5500, 1, 4'h0, 0, 8'h00, 0, 4'h0, 0, 0);
        vecs[9]  = mk(0, 4'h2, 4'h0, 32'h0000_5500, 1, 4'h2, 1, 8'h55, 0, 4'h2, 1, 0);
        vecs[10] = mk(1, 4'h2, 4'h0, 32'h0000_5600, 1, 4'h2, 0, 8'h00, 0, 4'h0, 1, 0);
        // after reset ports 0 and 1 both request: port 0 first
        vecs[11] = mk(0, 4'h3, 4'h1, 32'h0000_5710, 1, 4'h0, 0, 8'h00, 0, 4'h0, 0, 0);
        vecs[12] = mk(0, 4'h3, 4'h1, 32'h0000_5710, 1, 4'h1, 1, 8'h10, 1, 4'h1, 1, 0);
        vecs[13] = mk(0, 4'h2, 4'h2, 32'h0000_5700, 1, 4'h0, 0, 8'h00, 0, 4'h0, 0, 0);
        vecs[14] = mk(0, 4'h2, 4'h2, 32'h0000_5700, 1, 4'h2, 1, 8'h57, 1, 4'h2, 1, 0);
        vecs[15] = mk(0, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 0, 8'h00, 0, 4'h0, 0, 0);

        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            next_cycle();
            rst           = vecs[i].rst;
            s_axis_tvalid = vecs[i].valid;
            s_axis_tlast  = vecs[i].last;
            s_axis_tdata  = vecs[i].data;
            m_axis_tready = vecs[i].mready;
            settle();
            $display("vec %0d: rst=%0b valid=%h grant=%h mvalid=%0b mdata=%h mlast=%0b tready=%h busy=%0b terr=%0b",
                     i, rst, s_axis_tvalid, grant, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                     s_axis_tready, busy, timeout_err);
            chk($sformatf("vec%0d_grant", i),  32'(grant),         32'(vecs[i].e_grant));
            chk($sformatf("vec%0d_mvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].e_mvalid));
            chk($sformatf("vec%0d_tready", i), 32'(s_axis_tready), 32'(vecs[i].e_tready));
            chk($sformatf("vec%0d_busy", i),   32'(busy),          32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_terr", i),   32'(timeout_err),   32'(vecs[i].e_terr));
            if (vecs[i].e_mvalid) begin
                chk($sformatf("vec%0d_mdata", i), 32'(m_axis_tdata), 32'(vecs[i].e_mdata));
                chk($sformatf("vec%0d_mlast", i), 32'(m_axis_tlast), 32'(vecs[i].e_mlast));
            end
        end

        // ---------------- round robin, all ports, 1-byte messages ----------------
        next_cycle();
        rst           = 1'b1;
        s_axis_tvalid = '0;
        settle();
        next_cycle();
        rst           = 1'b0;
        s_axis_tvalid = 4'hF;
        s_axis_tlast  = 4'hF;
        s_axis_tdata  = 32'hC3C2_C1C0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("rr%0d_idle_grant", k), 32'(grant), 32'h0);
            next_cycle();
            settle();
            $display("rr %0d: grant=%h mdata=%h mlast=%0b", k, grant, m_axis_tdata, m_axis_tlast);
            chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr%0d_mdata", k), 32'(m_axis_tdata), 32'(8'hC0 + k % 4));
            chk($sformatf("rr%0d_mlast", k), 32'(m_axis_tlast), 32'h1);
            next_cycle();
        end

        // ---------------- long backpressure: no timeout ----------------
        // last_owner is now port 3, so port 0 is picked.
        s_axis_tvalid = 4'h1;
        s_axis_tlast  = 4'h1;
        s_axis_tdata  = 32'h0000_0077;
        m_axis_tready = 1'b0;
        settle();
        chk("bp_idle_grant", 32'(grant), 32'h0);
        bad_cnt = 0;
        for (int c = 0; c < 5000; c++) begin
            next_cycle();
            settle();
            if (grant !== 4'h1 || timeout_err !== 1'b0 || m_axis_tvalid !== 1'b1 ||
                m_axis_tdata !== 8'h77 || s_axis_tready !== 4'h0)
                bad_cnt++;
        end
        $display("bp: 5000 stalled cycles, deviations=%0d", bad_cnt);
        chk("bp_stable_during_stall", 32'(bad_cnt), 32'h0);
        next_cycle();
        m_axis_tready = 1'b1;
        settle();
        chk("bp_release_tready", 32'(s_axis_tready), 32'h1);
        chk("bp_release_mdata",  32'(m_axis_tdata),  32'h77);
        chk("bp_release_mlast",  32'(m_axis_tlast),  32'h1);
        next_cycle();
        s_axis_tvalid = 4'h0;
        settle();
        chk("bp_after_grant", 32'(grant),       32'h0);
        chk("bp_after_terr",  32'(timeout_err), 32'h0);

        // ---------------- idle timeout ----------------
        // last_owner is port 0: port 1 wins over waiting port 3.
        next_cycle();
        s_axis_tvalid = 4'hA;
        s_axis_tlast  = 4'h8;
        s_axis_tdata  = 32'h3300_3100;
        settle();
        next_cycle();
        settle();
        chk("to_grant_p1", 32'(grant),        32'h2);
        chk("to_beat",     32'(m_axis_tdata), 32'h31);
        next_cycle();
        s_axis_tvalid = 4'h8;       // port 1 goes silent
        bad_cnt  = 0;
        terr_cnt = 0;
        for (int c = 0; c < TO; c++) begin
            settle();
            if (grant !== 4'h2 || busy !== 1'b1) bad_cnt++;
            if (timeout_err === 1'b1) terr_cnt++;
            next_cycle();
        end
        chk("to_grant_held", 32'(bad_cnt), 32'h0);
        settle();
        $display("to: grant=%h busy=%0b timeout_err=%0b", grant, busy, timeout_err);
        chk("to_pulse",       32'(timeout_err), 32'h1);
        chk("to_grant_clear", 32'(grant),       32'h0);
        chk("to_busy_clear",  32'(busy),        32'h0);
        terr_cnt += (timeout_err === 1'b1) ? 1 : 0;
        next_cycle();
        settle();
        terr_cnt += (timeout_err === 1'b1) ? 1 : 0;
        chk("to_next_grant", 32'(grant),        32'h8);
        chk("to_next_mdata", 32'(m_axis_tdata), 32'h33);
        chk("to_pulse_once", 32'(terr_cnt),     32'h1);
        next_cycle();
        s_axis_tvalid = 4'h0;
        settle();
        chk("to_final_idle", 32'(grant), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, meaning the number of requester ports (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the byte width passed to the UART transmitter.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the number of consecutive idle cycles from the granted port before its grant is revoked (>=2).
REQ-004 clk  input  1  the single clock; all logic rises on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 s_axis_tdata  input  NUM_PORTS*DATA_WIDTH  requester bytes; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_axis_tvalid  input  NUM_PORTS  per-port byte valid.
REQ-008 s_axis_tlast  input  NUM_PORTS  per-port end-of-message marker.
REQ-009 s_axis_tready  output  NUM_PORTS  per-port byte accepted.
REQ-010 m_axis_tdata  output  DATA_WIDTH  byte to UART transmitter.
REQ-011 m_axis_tvalid  output  1  byte valid to UART transmitter.
REQ-012 m_axis_tready  input  1  UART transmitter ready.
REQ-013 m_axis_tlast  output  1  end-of-message flag, forwarded.
REQ-014 grant  output  NUM_PORTS  one-hot current owner; all-zero when idle.
REQ-015 busy  output  1  high while a port holds the grant.
REQ-016 timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 The block SHALL implement two states: IDLE and PASS.
REQ-018 In IDLE, grant, s_axis_tready and m_axis_tvalid SHALL be all zero, and busy SHALL be 0.
REQ-019 In IDLE with any s_axis_tvalid set, the block SHALL select round-robin the first asserting port after last_owner (wrapping NUM_PORTS-1 -> 0), register it in grant, and enter PASS on the next edge.
REQ-020 Arbitration latency SHALL be exactly one cycle from the first valid seen in IDLE to grant assertion; no byte transfers in the arbitration cycle.
REQ-021 In PASS with owner g, m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL combinationally equal port g's tdata, tvalid and tlast.
REQ-022 In PASS, s_axis_tready[g] SHALL equal m_axis_tready, and s_axis_tready SHALL be 0 for all other ports.
REQ-023 A beat SHALL transfer only when m_axis_tvalid and m_axis_tready are both high; no byte SHALL be dropped or duplicated.
REQ-024 On a transferred beat with tlast=1, the block SHALL return to IDLE on that edge, set last_owner=g, and clear grant.
REQ-025 Non-granted ports SHALL be held off and SHALL keep their valid and data stable; the grant SHALL not change mid-message.
REQ-026 A timeout counter SHALL clear on entry to PASS and on every transferred beat, and increment each PASS cycle in which s_axis_tvalid[g]=0.
REQ-027 The counter SHALL saturate and never wrap.
REQ-028 Cycles with tvalid=1 and m_axis_tready=0 SHALL not count, so backpressure never causes timeout.
REQ-029 When the counter reaches TIMEOUT-1 and the current cycle also counts, the block SHALL return to IDLE, set last_owner=g, and pulse timeout_err for exactly one cycle.
REQ-030 Release and re-arbitration SHALL not overlap: after any release, the block SHALL spend at least one cycle in IDLE, and a pending port is granted on the following edge.
REQ-031 When the releasing port is the only requester, it SHALL be re-granted after the IDLE cycle.
REQ-032 Port index arithmetic SHALL be modulo NUM_PORTS; the counter SHALL be $clog2(TIMEOUT+1) bits wide.

Reset
REQ-033 When rst is sampled high, the block SHALL enter IDLE; grant=0, busy=0, timeout_err=0, counter=0, last_owner=NUM_PORTS-1 (port 0 highest priority first).
REQ-034 Reset asserted mid-message SHALL abort the message on that edge with no further beats forwarded.
REQ-035 While rst is high, all s_axis_tready and m_axis_tvalid SHALL be 0.

Verification
REQ-036 Out of reset, ports 0 and 2 assert simultaneously -> port 0 is granted 1 cycle later, its 3-byte message 0x41,0x42,0x43 (last on 0x43) is forwarded in order, then port 2 is granted after 1 IDLE cycle.
REQ-037 All 4 ports request continuously with 1-byte messages -> grant order is 0,1,2,3,0,..., and each grant lasts until its tlast beat.
REQ-038 m_axis_tready is held low for 5000 cycles during a message -> no timeout, tdata stable, and the byte transfers when ready rises.
REQ-039 The granted port drops tvalid for TIMEOUT=16 cycles mid-message -> timeout_err pulses exactly once, grant clears, and the next requester is granted after 1 cycle.
REQ-040 rst is pulsed for 1 cycle while port 1 is mid-message -> grant=0 next cycle, no further beats forward, and port 0 wins if both ports 0 and 1 then request.
